// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: drains bytes from the UART receiver over a ready/ack handshake
// and presents them oldest-first to the CPU, with a fill level and a sticky overrun flag.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ack,
  output logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ack,
  input  logic              flush,
  input  logic              clr_overrun,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam logic [1:0] IN_IDLE = 2'd0;
  localparam logic [1:0] IN_ACK  = 2'd1;
  localparam logic [1:0] IN_WAIT = 2'd2;

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  assign push_req = (state == IN_IDLE) && in_ready;
  assign full     = (count == CNT_DEPTH);
  assign pop      = out_ack && (count != '0) && !flush;
  // A full FIFO still accepts the byte when a pop frees a slot on the same edge.
  assign push_ok  = push_req && !flush && (!full || pop);
  assign drop     = push_req && !flush && full && !pop;

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IN_IDLE;
      in_ack <= 1'b0;
    end else begin
      in_ack <= 1'b0;
      case (state)
        IN_IDLE: if (in_ready) begin
          in_ack <= 1'b1;
          state  <= IN_ACK;
        end
        IN_ACK:  state <= IN_WAIT;
        IN_WAIT: if (!in_ready) state <= IN_IDLE;
        default: state <= IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (pop && !push_ok) count <= count - CNT_ONE;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because
  // out_data is gated by count, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  // NOTE: every output of this combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    out_data  = '0;
    out_ready = (count != '0);
    if (out_ready) out_data = mem[rd_ptr];
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a receiver model, a byte scoreboard queue,
// a table for the fill/overrun sequence and hand-written multi-cycle corner cases.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_ack;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ack;
  logic       flush;
  logic       clr_overrun;
  logic [4:0] count;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    logic       exp_ovr;
  } vec_t;
  vec_t fill_tbl[17];

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .in_data(in_data), .in_ack(in_ack),
    .out_ready(out_ready), .out_data(out_data), .out_ack(out_ack), .flush(flush),
    .clr_overrun(clr_overrun), .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Receiver model: present a byte, wait for the ack, drop ready, let the FSM return to idle.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    in_data  = b;
    in_ready = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (in_ack) got = 1;
    end
    check("ack_seen", 32'(got), 32'd1);
    in_ready = 1'b0;
    if (exp_q.size() < 16) exp_q.push_back(b);
    step();
    check("ack_one_cycle", 32'(in_ack), 32'd0);
    step();
  endtask

  task automatic pop_byte();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("pop_model_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("pop_ready", 32'(out_ready), 32'd1);
      check("pop_data", 32'(out_data), 32'(e));
    end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 17; i++) begin
      fill_tbl[i].data      = (i < 16) ? 8'(i + 1) : 8'h55;
      fill_tbl[i].exp_count = (i < 16) ? i + 1 : 16;
      fill_tbl[i].exp_ovr   = (i == 16);
    end

    rst_n = 1'b0; in_ready = 0; in_data = 0; out_ack = 0; flush = 0; clr_overrun = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(out_ready), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ack", 32'(in_ack), 0);
    check("rst_ovr", 32'(overrun), 0);

    // Byte held for three cycles must be captured exactly once.
    begin
      int acks = 0;
      in_data = 8'h41; in_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); if (in_ack) acks++; end
      in_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin step(); if (in_ack) acks++; end
      check("hold_acks", 32'(acks), 1);
      check("hold_count", 32'(count), 1);
      exp_q.push_back(8'h41);
      pop_byte();
      check("hold_pop_count", 32'(count), 0);
      check("hold_pop_ready", 32'(out_ready), 0);
    end

    for (int i = 0; i < 17; i++) begin
      send_byte(fill_tbl[i].data);
      check("fill_count", 32'(count), 32'(fill_tbl[i].exp_count));
      check("fill_ovr", 32'(overrun), 32'(fill_tbl[i].exp_ovr));
    end
    for (int i = 0; i < 16; i++) pop_byte();
    check("drain_count", 32'(count), 0);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("clr_ovr", 32'(overrun), 0);

    // Full FIFO: push of 0x77 on the same edge as a pop is accepted.
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1));
    check("full_count", 32'(count), 16);
    check("sim_head", 32'(out_data), 32'h01);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    in_data = 8'h77; in_ready = 1'b1; out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    check("sim_ack", 32'(in_ack), 1);
    in_ready = 1'b0;
    step(); step();
    check("sim_count", 32'(count), 16);
    check("sim_ovr", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) pop_byte();
    check("sim_drain", 32'(count), 0);

    // Wrap the pointers with immediate push/pop pairs.
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(8'h80 + i));
      check("wrap_count", 32'(count), 1);
      pop_byte();
    end
    check("wrap_end", 32'(count), 0);

    // Empty pop is ignored.
    out_ack = 1'b1; step(); out_ack = 1'b0;
    check("underflow_count", 32'(count), 0);

    // Flush with an incoming byte: acked, dropped, no overrun.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i));
    check("pre_flush", 32'(count), 5);
    in_data = 8'h33; in_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ack", 32'(in_ack), 1);
    in_ready = 1'b0;
    step(); step();
    exp_q.delete();
    check("flush_count", 32'(count), 0);
    check("flush_ready", 32'(out_ready), 0);
    check("flush_ovr", 32'(overrun), 0);

    // clr_overrun coinciding with a drop: set wins.
    for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i));
    in_data = 8'h99; in_ready = 1'b1; clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("drop_ack", 32'(in_ack), 1);
    check("setclr_ovr", 32'(overrun), 1);
    in_ready = 1'b0;
    step(); step();
    check("drop_count", 32'(count), 16);
    flush = 1'b1; step(); flush = 1'b0;
    exp_q.delete();
    check("flush_keeps_ovr", 32'(overrun), 1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("clr_ovr2", 32'(overrun), 0);

    // Reset mid-handshake: ack drops at once, held byte is captured again afterwards.
    in_data = 8'hA5; in_ready = 1'b1;
    step();
    check("mid_ack", 32'(in_ack), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(in_ack), 0);
    check("mid_rst_count", 32'(count), 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ack", 32'(in_ack), 1);
    in_ready = 1'b0;
    exp_q.push_back(8'hA5);
    step(); step();
    check("post_rst_count", 32'(count), 1);
    pop_byte();
    check("post_rst_empty", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
